// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared MDU op encodings, MDU state enum and default latencies
package pipe_ctrl_pkg;
  typedef logic [1:0] md_op_t;
  localparam md_op_t MD_NONE = 2'b00;
  localparam md_op_t MD_MUL = 2'b01;
  localparam md_op_t MD_DIV = 2'b10;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  localparam int CNT_W_DEF = 6;
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard inputs and pipeline-register enables between datapath and controller
interface pipe_stall_ctrl_if import pipe_ctrl_pkg::*; ();
  logic id_ex_mem_read;
  logic [4:0] id_ex_rt;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic id_uses_hilo;
  md_op_t ex_md_op;
  logic ex_branch_taken;
  logic dmem_req;
  logic dmem_ready;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic pipe_freeze;
  logic md_start;
  logic md_busy;
  logic md_done;
  modport master (
    output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, id_uses_hilo, ex_md_op,
           ex_branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           md_start, md_busy, md_done
  );
  modport slave (
    input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, id_uses_hilo, ex_md_op,
           ex_branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           md_start, md_busy, md_done
  );
endinterface

// File: rtl/pipe_stall_ctrl_md_seq.sv
// md_seq: MDU sequencer, IDLE/BUSY FSM with latency down-counter
module md_seq import pipe_ctrl_pkg::*; #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req,
  input  md_op_t op,
  input  logic   hold,
  output logic   md_start,
  output logic   md_busy,
  output logic   md_done
);
  md_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    md_busy = state_q == MD_BUSY;
    md_done = md_busy && cnt_q == '0;
    md_start = !md_busy && req && !hold;
    state_d = md_start ? MD_BUSY : md_done ? MD_IDLE : state_q;
    cnt_d = md_start ? (op == MD_DIV ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1)) :
            (md_busy && !md_done) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush/freeze priority and MDU sequencing; PIPE_STALL_PERF_EN adds perf counters
module pipe_stall_ctrl import pipe_ctrl_pkg::*; #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  pipe_stall_ctrl_if.slave p
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] freeze_cycles,
  output logic [31:0] flush_count
`endif
);
  logic load_use, md_hazard, mem_wait, stall, md_req;
  assign load_use = p.id_ex_mem_read && (p.id_ex_rt == p.if_id_rs || p.id_ex_rt == p.if_id_rt);
  assign md_hazard = p.md_busy && p.id_uses_hilo;
  assign mem_wait = p.dmem_req && !p.dmem_ready;
  assign stall = load_use || md_hazard;
  assign md_req = p.ex_md_op == MD_MUL || p.ex_md_op == MD_DIV;
  // a taken branch squashes the ID instruction, so its hazards no longer matter
  always_comb begin
    p.pipe_freeze = mem_wait;
    p.pc_write = !mem_wait && (p.ex_branch_taken || !stall);
    p.if_id_write = !mem_wait && (p.ex_branch_taken || !stall);
    p.if_id_flush = !mem_wait && p.ex_branch_taken;
    p.id_ex_bubble = !mem_wait && (p.ex_branch_taken || stall);
  end
  md_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_md_seq (
    .clk(clk),
    .rst_n(rst_n),
    .req(md_req),
    .op(p.ex_md_op),
    .hold(mem_wait),
    .md_start(p.md_start),
    .md_busy(p.md_busy),
    .md_done(p.md_done)
  );
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] freeze_cycles_q, freeze_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  always_comb begin
    stall_cycles_d = stall_cycles_q + 32'(!mem_wait && !p.ex_branch_taken && stall);
    freeze_cycles_d = freeze_cycles_q + 32'(mem_wait);
    flush_count_d = flush_count_q + 32'(!mem_wait && p.ex_branch_taken);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cycles_q <= '0;
      freeze_cycles_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      freeze_cycles_q <= freeze_cycles_d;
      flush_count_q <= flush_count_d;
    end
  assign stall_cycles = stall_cycles_q;
  assign freeze_cycles = freeze_cycles_q;
  assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of hazard priority, MDU sequencing and reset abort
module tb_pipe_stall_ctrl;
  import pipe_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  pipe_stall_ctrl_if bus();
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cycles, freeze_cycles, flush_count;
`endif
  pipe_stall_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .p(bus)
`ifdef PIPE_STALL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .freeze_cycles(freeze_cycles),
    .flush_count(flush_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic pc, input logic ifw, input logic fl,
                      input logic bub, input logic frz);
    chk({tag, ".pc_write"}, bus.pc_write, pc);
    chk({tag, ".if_id_write"}, bus.if_id_write, ifw);
    chk({tag, ".if_id_flush"}, bus.if_id_flush, fl);
    chk({tag, ".id_ex_bubble"}, bus.id_ex_bubble, bub);
    chk({tag, ".pipe_freeze"}, bus.pipe_freeze, frz);
  endtask
  task automatic md(input string tag, input logic st, input logic busy, input logic done);
    chk({tag, ".md_start"}, bus.md_start, st);
    chk({tag, ".md_busy"}, bus.md_busy, busy);
    chk({tag, ".md_done"}, bus.md_done, done);
  endtask
  task automatic idle();
    bus.id_ex_mem_read = 0;
    bus.id_ex_rt = 0;
    bus.if_id_rs = 0;
    bus.if_id_rt = 0;
    bus.id_uses_hilo = 0;
    bus.ex_md_op = MD_NONE;
    bus.ex_branch_taken = 0;
    bus.dmem_req = 0;
    bus.dmem_ready = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    #1 rst_n = 0;
    #10;
    outs("reset", 1, 1, 0, 0, 0);
    md("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    // load-use on rs: exactly one bubble
    bus.id_ex_mem_read = 1; bus.id_ex_rt = 8; bus.if_id_rs = 8; bus.if_id_rt = 3;
    #2 outs("load_use", 0, 0, 0, 1, 0);
    tick();
    bus.id_ex_mem_read = 0;
    #2 outs("load_use_after", 1, 1, 0, 0, 0);
    bus.id_ex_mem_read = 1; bus.id_ex_rt = 3; bus.if_id_rs = 9;
    #2 outs("load_use_rt", 0, 0, 0, 1, 0);
    bus.id_ex_rt = 7;
    #2 outs("load_no_dep", 1, 1, 0, 0, 0);
    tick();
    idle();
    // mult then dependent hilo instruction
    bus.ex_md_op = MD_MUL;
    #2 md("mul_start", 1, 0, 0);
    tick();
    bus.ex_md_op = MD_NONE; bus.id_uses_hilo = 1;
    for (int k = 1; k <= 4; k++) begin
      #2 md($sformatf("mul_c%0d", k), 0, 1, k == 4);
      outs($sformatf("mul_c%0d", k), 0, 0, 0, 1, 0);
      tick();
    end
    #2 md("mul_end", 0, 0, 0);
    outs("mul_end", 1, 1, 0, 0, 0);
    tick();
    idle();
    // div with a 3-cycle memory wait; an MDU op arriving while busy is ignored
    bus.ex_md_op = MD_DIV;
    #2 md("div_start", 1, 0, 0);
    tick();
    for (int k = 1; k <= 32; k++) begin
      bus.dmem_req = (k >= 3 && k <= 5);
      bus.ex_md_op = (k == 10) ? MD_MUL : MD_NONE;
      #2 md($sformatf("div_c%0d", k), 0, 1, k == 32);
      chk($sformatf("div_c%0d.pipe_freeze", k), bus.pipe_freeze, k >= 3 && k <= 5);
      chk($sformatf("div_c%0d.pc_write", k), bus.pc_write, !(k >= 3 && k <= 5));
      tick();
    end
    idle();
    #2 md("div_end", 0, 0, 0);
    tick();
    // branch together with load-use, then under freeze, then released
    bus.id_ex_mem_read = 1; bus.id_ex_rt = 5; bus.if_id_rt = 5; bus.ex_branch_taken = 1;
    #2 outs("br_lu", 1, 1, 1, 1, 0);
    tick();
    bus.dmem_req = 1; bus.dmem_ready = 0;
    #2 outs("br_frz1", 0, 0, 0, 0, 1);
    md("br_frz1", 0, 0, 0);
    tick();
    #2 outs("br_frz2", 0, 0, 0, 0, 1);
    tick();
    bus.dmem_ready = 1;
    #2 outs("br_rel", 1, 1, 1, 1, 0);
    tick();
    idle();
    #2 outs("br_after", 1, 1, 0, 0, 0);
`ifdef PIPE_STALL_PERF_EN
    chk32("perf.stall_cycles", stall_cycles, 32'd5);
    chk32("perf.freeze_cycles", freeze_cycles, 32'd5);
    chk32("perf.flush_count", flush_count, 32'd2);
`endif
    tick();
    // div held off by memory wait, launches once ready, then reset at counter 10
    bus.ex_md_op = MD_DIV; bus.dmem_req = 1; bus.dmem_ready = 0;
    #2 md("div_hold", 0, 0, 0);
    chk("div_hold.pipe_freeze", bus.pipe_freeze, 1);
    tick();
    bus.dmem_ready = 1;
    #2 md("div_launch", 1, 0, 0);
    tick();
    idle();
    for (int k = 1; k < 22; k++) tick();
    #2 md("div_c22", 0, 1, 0);
    #1 rst_n = 0;
    #1 md("rst_abort", 0, 0, 0);
`ifdef PIPE_STALL_PERF_EN
    chk32("rst.freeze_cycles", freeze_cycles, 32'd0);
`endif
    for (int k = 1; k <= 3; k++) begin
      tick();
      #2 chk($sformatf("rst_hold%0d.md_done", k), bus.md_done, 0);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    #2 md("post_rst", 0, 0, 0);
    outs("post_rst", 1, 1, 0, 0, 0);
    bus.ex_md_op = MD_MUL;
    #2 md("mul2_start", 1, 0, 0);
    tick();
    bus.ex_md_op = MD_NONE; bus.id_uses_hilo = 1;
    for (int k = 1; k <= 4; k++) begin
      #2 md($sformatf("mul2_c%0d", k), 0, 1, k == 4);
      chk($sformatf("mul2_c%0d.pc_write", k), bus.pc_write, 0);
      tick();
    end
    #2 md("mul2_end", 0, 0, 0);
    chk("mul2_end.pc_write", bus.pc_write, 1);
`ifdef PIPE_STALL_PERF_EN
    chk32("perf2.stall_cycles", stall_cycles, 32'd4);
    chk32("perf2.freeze_cycles", freeze_cycles, 32'd0);
    chk32("perf2.flush_count", flush_count, 32'd0);
`endif
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
